lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter F3_B, default 3'd0, meaning funct3 for LB and SB.
REQ-002 SHALL have parameter F3_H, default 3'd1, meaning funct3 for LH and SH.
REQ-003 SHALL have parameter F3_W, default 3'd2, meaning funct3 for LW and SW.
REQ-004 SHALL have parameter F3_BU, default 3'd4, meaning funct3 for LBU.
REQ-005 SHALL have parameter F3_HU, default 3'd5, meaning funct3 for LHU.
REQ-006 SHALL have one clock and an asynchronous active-low reset: CLK in 1, system clock; RST_N in 1, reset asserted low.
REQ-007 SHALL have these core-side ports: req_valid in 1; req_ready out 1; req_load in 1; req_store in 1; req_funct3 in 3; req_addr in MXLEN; req_wdata in MXLEN; flush in 1, abort the in-flight access.
REQ-008 SHALL have these response ports: resp_valid out 1; resp_rdata out MXLEN; resp_load_misaligned out 1; resp_store_misaligned out 1.
REQ-009 SHALL have these memory-side ports: mem_req out 1; mem_we out 1; mem_addr out MXLEN; mem_wdata out MXLEN; mem_be out 4; mem_gnt in 1; mem_rvalid in 1; mem_rdata in MXLEN.

Function
REQ-010 SHALL implement the FSM states IDLE, REQ, WAIT, DRAIN and RESP.
REQ-011 SHALL drive req_ready=1 only in IDLE; a request is accepted on the edge where req_valid&&req_ready.
REQ-012 SHALL, on acceptance, register addr, wdata, funct3 and direction; load SHALL win when req_load and req_store are both 1.
REQ-013 SHALL detect misalignment at acceptance: H/HU with addr[0]!=0, or W with addr[1:0]!=0.
REQ-014 SHALL, on a misaligned request, go IDLE->RESP with no mem_req and set the matching flag, with resp_rdata=0.
REQ-015 SHALL treat an unsupported funct3, or a request with neither load nor store, as a no-op: go IDLE->RESP with rdata=0, both flags 0 and no memory access.
REQ-016 SHALL, for a valid aligned access, go IDLE->REQ.
REQ-017 SHALL, in REQ, hold mem_req=1 and mem_addr={addr[31:2],2'b00}, with mem_we, mem_be and mem_wdata held stable until mem_gnt.
REQ-018 SHALL drive mem_be as B: 4'b0001<<addr[1:0]; H: 4'b0011<<addr[1:0]; W: 4'b1111.
REQ-019 SHALL drive mem_wdata as B: {4{wdata[7:0]}}; H: {2{wdata[15:0]}}; W: wdata.
REQ-020 SHALL, in REQ with mem_gnt=1, go to RESP for a store and to WAIT for a load.
REQ-021 SHALL, in WAIT on mem_rvalid, capture the byte/halfword lane selected by addr[1:0], sign-extend it for B/H, zero-extend it for BU/HU, and go to RESP.
REQ-022 SHALL, in RESP, assert resp_valid for exactly one cycle with its outputs valid, then return to IDLE; there is no response backpressure.
REQ-023 SHALL give minimum latency from acceptance edge T: store resp_valid at T+2, load resp_valid at T+3, misaligned or no-op resp_valid at T+1.
REQ-024 SHALL, on flush in REQ, drop mem_req next cycle, go to IDLE and issue no response.
REQ-025 SHALL, on flush in WAIT, go to DRAIN, consume the pending mem_rvalid, discard the data, go to IDLE and issue no response.
REQ-026 SHALL, on flush in RESP, still emit that resp_valid; flush in IDLE or DRAIN has no effect.
REQ-027 SHALL assert mem_req only in REQ and SHALL ignore mem_rvalid outside WAIT and DRAIN.
REQ-028 SHALL have at most one access outstanding at any time.

Reset
REQ-029 SHALL, while RST_N=0, hold the state at IDLE and drive every output to 0 except req_ready, which is 1.
REQ-030 SHALL, on reset mid-access, abandon the access and emit no response; the memory side is reset by the same RST_N.

Verification
REQ-031 SHALL cover: LW addr 0x10 with mem_rdata 0x8899AABB and gnt and rvalid immediate -> mem_be 4'b1111, resp_rdata 0x8899AABB at T+3.
REQ-032 SHALL cover: LB addr 0x13 with rdata 0x80000000 -> resp_rdata 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-033 SHALL cover: SH addr 0x22 with wdata 0x1234, gnt delayed 3 cycles -> mem_be 4'b1100 and mem_wdata 0x12341234 held stable, resp_valid 1 cycle after gnt.
REQ-034 SHALL cover: LW addr 0x01 -> no mem_req, resp_load_misaligned=1 and resp_rdata=0 at T+1; SW addr 0x02 -> resp_store_misaligned=1.
REQ-035 SHALL cover: LW with flush in WAIT, rvalid 2 cycles later -> no resp_valid, req_ready back to 1 the cycle after rvalid.
REQ-036 SHALL cover: RST_N low for 1 cycle while in REQ -> mem_req=0 immediately, IDLE, no response.

Source files
------------

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - core-side and memory-side bundles of the load/store unit
//
// lsu_core_if : request/flush from the core, one-cycle response back.
//   master = core, slave = lsu.
// lsu_mem_if  : single-outstanding request/grant/rvalid memory port.
//   master = lsu, slave = memory.

interface lsu_core_if #(parameter int MXLEN = 32);
    logic             req_valid;
    logic             req_ready;
    logic             req_load;
    logic             req_store;
    logic [2:0]       req_funct3;
    logic [MXLEN-1:0] req_addr;
    logic [MXLEN-1:0] req_wdata;
    logic             flush;
    logic             resp_valid;
    logic [MXLEN-1:0] resp_rdata;
    logic             resp_load_misaligned;
    logic             resp_store_misaligned;

    modport master (
        output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, flush,
        input  req_ready, resp_valid, resp_rdata, resp_load_misaligned, resp_store_misaligned
    );
    modport slave (
        input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, flush,
        output req_ready, resp_valid, resp_rdata, resp_load_misaligned, resp_store_misaligned
    );
endinterface

interface lsu_mem_if #(parameter int MXLEN = 32);
    logic             mem_req;
    logic             mem_we;
    logic [MXLEN-1:0] mem_addr;
    logic [MXLEN-1:0] mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [MXLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit with misalignment and flush handling
//
// Ports: CLK, RST_N (async, active low); core (lsu_core_if.slave): request,
// flush and one-cycle response; mem (lsu_mem_if.master): req/gnt address
// phase followed by an rvalid data phase for loads.

module lsu #(
    parameter logic [2:0] F3_B  = 3'd0,
    parameter logic [2:0] F3_H  = 3'd1,
    parameter logic [2:0] F3_W  = 3'd2,
    parameter logic [2:0] F3_BU = 3'd4,
    parameter logic [2:0] F3_HU = 3'd5,
    parameter int         MXLEN = 32
) (
    input  logic       CLK,
    input  logic       RST_N,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, RESP} state_t;

    state_t           state, state_nxt;
    logic [MXLEN-1:0] addr_q, wdata_q, rdata_q;
    logic [2:0]       f3_q;
    logic             is_load_q, lmis_q, smis_q;

    // Acceptance-time decode; load wins when both directions are requested.
    logic       accept, acc_load, acc_store, acc_valid, acc_mis;
    logic [2:0] f3;
    assign f3        = core.req_funct3;
    assign accept    = core.req_valid && (state == IDLE);
    assign acc_load  = core.req_load;
    assign acc_store = !core.req_load && core.req_store;
    // Stores have no unsigned variants, so BU/HU stores fall into the no-op path.
    assign acc_valid = (acc_load  && (f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                                      f3 == F3_BU || f3 == F3_HU)) ||
                       (acc_store && (f3 == F3_B || f3 == F3_H || f3 == F3_W));
    assign acc_mis   = acc_valid &&
                       (((f3 == F3_H || f3 == F3_HU) && core.req_addr[0]) ||
                        ((f3 == F3_W) && (core.req_addr[1:0] != 2'b00)));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = (!acc_valid || acc_mis) ? RESP : REQ;
            // A load granted in the same cycle as the flush still owes an
            // rvalid, so it must be drained before another access can start.
            REQ:   if (core.flush)        state_nxt = (mem.mem_gnt && is_load_q) ? DRAIN : IDLE;
                   else if (mem.mem_gnt)  state_nxt = is_load_q ? WAIT : RESP;
            WAIT:  if (mem.mem_rvalid)    state_nxt = core.flush ? IDLE : RESP;
                   else if (core.flush)   state_nxt = DRAIN;
            DRAIN: if (mem.mem_rvalid)    state_nxt = IDLE;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Selected lane moved to bit 0, then sign/zero extended by access size.
    logic [MXLEN-1:0] shifted, ext;
    assign shifted = mem.mem_rdata >> {addr_q[1:0], 3'b000};
    always_comb begin
        ext = shifted;
        case (f3_q)
            F3_B:    ext = {{(MXLEN-8){shifted[7]}},   shifted[7:0]};
            F3_BU:   ext = {{(MXLEN-8){1'b0}},         shifted[7:0]};
            F3_H:    ext = {{(MXLEN-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   ext = {{(MXLEN-16){1'b0}},        shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            f3_q      <= 3'd0;
            is_load_q <= 1'b0;
            lmis_q    <= 1'b0;
            smis_q    <= 1'b0;
        end else if (accept) begin
            addr_q    <= core.req_addr;
            wdata_q   <= core.req_wdata;
            rdata_q   <= '0;
            f3_q      <= f3;
            is_load_q <= acc_load;
            lmis_q    <= acc_mis && acc_load;
            smis_q    <= acc_mis && acc_store;
        end else if (state == WAIT && mem.mem_rvalid) begin
            rdata_q   <= ext;
        end
    end

    // Memory outputs are forced to zero outside REQ so reset and idle are quiet.
    logic in_req, in_resp;
    logic [3:0]       be;
    logic [MXLEN-1:0] wd;
    assign in_req  = (state == REQ);
    assign in_resp = (state == RESP);

    always_comb begin
        be = 4'b1111;
        wd = wdata_q;
        case (f3_q)
            F3_B, F3_BU: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            F3_H, F3_HU: begin
                be = 4'b0011 << addr_q[1:0];
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
    end

    assign mem.mem_req   = in_req;
    assign mem.mem_we    = in_req && !is_load_q;
    assign mem.mem_addr  = in_req ? {addr_q[MXLEN-1:2], 2'b00} : '0;
    assign mem.mem_be    = in_req ? be : 4'b0000;
    assign mem.mem_wdata = in_req ? wd : '0;

    assign core.req_ready             = (state == IDLE);
    assign core.resp_valid            = in_resp;
    assign core.resp_rdata            = in_resp ? rdata_q : '0;
    assign core.resp_load_misaligned  = in_resp && lmis_q;
    assign core.resp_store_misaligned = in_resp && smis_q;
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu

module tb_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    lsu_core_if #(.MXLEN(32)) core ();
    lsu_mem_if  #(.MXLEN(32)) mem ();

    lsu dut (.CLK(clk), .RST_N(rst_n), .core(core.slave), .mem(mem.master));

    task automatic idle_inputs();
        core.req_valid = 1'b0; core.req_load = 1'b0; core.req_store = 1'b0;
        core.req_funct3 = 3'd0; core.req_addr = '0; core.req_wdata = '0;
        core.flush = 1'b0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
    endtask

    // Presents a request for one cycle; returns at the negedge after acceptance.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        core.req_valid = 1'b1; core.req_load = ld; core.req_store = st;
        core.req_funct3 = f3; core.req_addr = a; core.req_wdata = wd;
        @(negedge clk);
        core.req_valid = 1'b0; core.req_load = 1'b0; core.req_store = 1'b0;
    endtask

    // Load with immediate grant and rvalid; resp expected in the third cycle.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                            output logic [3:0] be, output logic [31:0] maddr,
                            output logic early, output logic vld, output logic [31:0] got);
        issue(1'b1, 1'b0, f3, a, 32'h0);
        be = mem.mem_be; maddr = mem.mem_addr; early = core.resp_valid;
        mem.mem_gnt = 1'b1;
        @(negedge clk);
        mem.mem_gnt = 1'b0;
        early = early | core.resp_valid | mem.mem_req;
        mem.mem_rvalid = 1'b1; mem.mem_rdata = rd;
        @(negedge clk);
        mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
        vld = core.resp_valid; got = core.resp_rdata;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        total++; if (core.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", core.req_ready); end
        total++; if (mem.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", mem.mem_req); end
        total++; if (core.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", core.resp_valid); end
        total++; if ({mem.mem_be, mem.mem_addr, core.resp_rdata} !== 68'h0) begin bad++; $display("FAIL reset_outputs be=%h addr=%h rdata=%h want 0", mem.mem_be, mem.mem_addr, core.resp_rdata); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        logic [3:0] be; logic [31:0] ma, got; logic early, vld;
        run_load(3'd2, 32'h10, 32'h8899AABB, be, ma, early, vld, got);
        total++; if (be !== 4'b1111) begin bad++; $display("FAIL lw_be got=%b want=1111", be); end
        total++; if (ma !== 32'h10) begin bad++; $display("FAIL lw_addr got=%h want=00000010", ma); end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL lw_early_resp got=%b want=0", early); end
        total++; if (vld !== 1'b1) begin bad++; $display("FAIL lw_resp_t3 got=%b want=1", vld); end
        total++; if (got !== 32'h8899AABB) begin bad++; $display("FAIL lw_rdata got=%h want=8899aabb", got); end
    endtask

    task automatic test_lb_lbu();
        logic [3:0] be; logic [31:0] ma, got; logic early, vld;
        run_load(3'd0, 32'h13, 32'h80000000, be, ma, early, vld, got);
        total++; if (got !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rdata got=%h want=ffffff80", got); end
        total++; if (be !== 4'b1000 || ma !== 32'h10) begin bad++; $display("FAIL lb_be_addr got=%b/%h want=1000/00000010", be, ma); end
        run_load(3'd4, 32'h13, 32'h80000000, be, ma, early, vld, got);
        total++; if (got !== 32'h00000080) begin bad++; $display("FAIL lbu_rdata got=%h want=00000080", got); end
        run_load(3'd5, 32'h12, 32'h9ABC0000, be, ma, early, vld, got);
        total++; if (got !== 32'h00009ABC) begin bad++; $display("FAIL lhu_rdata got=%h want=00009abc", got); end
    endtask

    task automatic test_sh();
        logic ok = 1'b1;
        issue(1'b0, 1'b1, 3'd1, 32'h22, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            if (mem.mem_req !== 1'b1 || mem.mem_we !== 1'b1 || mem.mem_be !== 4'b1100 ||
                mem.mem_wdata !== 32'h12341234 || mem.mem_addr !== 32'h20 || core.resp_valid !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL sh_hold be=%b wdata=%h req=%b want 1100/12341234/1", mem.mem_be, mem.mem_wdata, mem.mem_req); end
        mem.mem_gnt = 1'b1;
        @(negedge clk);
        mem.mem_gnt = 1'b0;
        total++; if (core.resp_valid !== 1'b1 || mem.mem_req !== 1'b0) begin bad++; $display("FAIL sh_resp valid=%b req=%b want=1/0", core.resp_valid, mem.mem_req); end
        @(negedge clk);
        total++; if (core.resp_valid !== 1'b0 || core.req_ready !== 1'b1) begin bad++; $display("FAIL sh_one_cycle valid=%b ready=%b want=0/1", core.resp_valid, core.req_ready); end
    endtask

    task automatic test_misaligned();
        issue(1'b1, 1'b0, 3'd2, 32'h01, 32'h0);
        total++; if (mem.mem_req !== 1'b0 || core.resp_valid !== 1'b1) begin bad++; $display("FAIL lw_mis_path req=%b valid=%b want=0/1", mem.mem_req, core.resp_valid); end
        total++; if (core.resp_load_misaligned !== 1'b1 || core.resp_store_misaligned !== 1'b0 || core.resp_rdata !== 32'h0) begin bad++; $display("FAIL lw_mis_flags lm=%b sm=%b rdata=%h want=1/0/0", core.resp_load_misaligned, core.resp_store_misaligned, core.resp_rdata); end
        issue(1'b0, 1'b1, 3'd2, 32'h02, 32'hDEADBEEF);
        total++; if (core.resp_store_misaligned !== 1'b1 || core.resp_load_misaligned !== 1'b0 || mem.mem_req !== 1'b0) begin bad++; $display("FAIL sw_mis_flags sm=%b lm=%b req=%b want=1/0/0", core.resp_store_misaligned, core.resp_load_misaligned, mem.mem_req); end
        issue(1'b1, 1'b0, 3'd1, 32'h03, 32'h0);
        total++; if (core.resp_load_misaligned !== 1'b1) begin bad++; $display("FAIL lh_mis got=%b want=1", core.resp_load_misaligned); end
    endtask

    task automatic test_noop();
        issue(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
        total++; if (core.resp_valid !== 1'b1 || mem.mem_req !== 1'b0 || core.resp_load_misaligned !== 1'b0 || core.resp_store_misaligned !== 1'b0) begin bad++; $display("FAIL noop_dir valid=%b req=%b lm=%b sm=%b want=1/0/0/0", core.resp_valid, mem.mem_req, core.resp_load_misaligned, core.resp_store_misaligned); end
        issue(1'b1, 1'b0, 3'd3, 32'h01, 32'h0);
        total++; if (core.resp_valid !== 1'b1 || mem.mem_req !== 1'b0 || core.resp_load_misaligned !== 1'b0 || core.resp_rdata !== 32'h0) begin bad++; $display("FAIL noop_f3 valid=%b req=%b lm=%b rdata=%h want=1/0/0/0", core.resp_valid, mem.mem_req, core.resp_load_misaligned, core.resp_rdata); end
    endtask

    task automatic test_flush_wait();
        logic seen = 1'b0;
        issue(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        mem.mem_gnt = 1'b1;
        @(negedge clk);
        mem.mem_gnt = 1'b0;
        core.flush = 1'b1;
        @(negedge clk);
        core.flush = 1'b0;
        seen = core.resp_valid | core.req_ready;
        @(negedge clk);
        seen = seen | core.resp_valid | core.req_ready;
        mem.mem_rvalid = 1'b1; mem.mem_rdata = 32'h55555555;
        @(negedge clk);
        mem.mem_rvalid = 1'b0;
        total++; if (seen !== 1'b0 || core.resp_valid !== 1'b0) begin bad++; $display("FAIL flush_wait_resp seen=%b valid=%b want=0/0", seen, core.resp_valid); end
        total++; if (core.req_ready !== 1'b1) begin bad++; $display("FAIL flush_wait_ready got=%b want=1", core.req_ready); end
    endtask

    task automatic test_flush_req();
        issue(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        core.flush = 1'b1;
        @(negedge clk);
        core.flush = 1'b0;
        total++; if (mem.mem_req !== 1'b0 || core.req_ready !== 1'b1 || core.resp_valid !== 1'b0) begin bad++; $display("FAIL flush_req req=%b ready=%b valid=%b want=0/1/0", mem.mem_req, core.req_ready, core.resp_valid); end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        issue(1'b0, 1'b1, 3'd2, 32'h40, 32'h11223344);
        total++; if (mem.mem_req !== 1'b1) begin bad++; $display("FAIL rst_mid_pre req=%b want=1", mem.mem_req); end
        rst_n = 1'b0;
        #1;
        total++; if (mem.mem_req !== 1'b0 || core.req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_async req=%b ready=%b want=0/1", mem.mem_req, core.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            seen = seen | core.resp_valid | mem.mem_req;
            @(negedge clk);
        end
        total++; if (seen !== 1'b0 || core.req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_after seen=%b ready=%b want=0/1", seen, core.req_ready); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misaligned();
        test_noop();
        test_flush_wait();
        test_flush_req();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
